// File: rtl/llc_rst_flush_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : llc_rst_flush_seq_pkg
// Brief    : Shared LLC constants and the reset/flush sequencer state type.
// Revision : 1.0 - initial release
// ============================================================================
package llc_rst_flush_seq_pkg;

    // Geometry of the last-level cache.
    localparam int LLC_SETS     = 512;
    localparam int LLC_WAYS     = 16;
    localparam int LLC_SET_BITS = $clog2(LLC_SETS);

    // Sequencer states for the reset and flush walks.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST_WR = 3'd1,
        ST_FL_RD  = 3'd2,
        ST_FL_CHK = 3'd3,
        ST_FL_WB  = 3'd4,
        ST_FL_WR  = 3'd5,
        ST_DONE   = 3'd6
    } llc_seq_state_t;

    // Index width that stays legal for a one-entry vector.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/llc_way_pick.sv
`default_nettype none
// ============================================================================
// Module   : llc_way_pick
// Brief    : Lowest-set-bit priority encoder over a way mask, with an
//            any-bit flag. Picks the next way to write back.
// Revision : 1.0 - initial release
// ============================================================================
module llc_way_pick
    import llc_rst_flush_seq_pkg::*;
#(
    parameter int WAYS     = LLC_WAYS,
    parameter int IDX_BITS = idx_bits(WAYS)
) (
    input  logic [WAYS-1:0]     i_mask,
    output logic [IDX_BITS-1:0] o_idx,
    output logic                o_any
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        o_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = IDX_BITS'(i);
            end
        end
        o_any = |i_mask;
    end

endmodule
`default_nettype wire

// File: rtl/llc_rst_flush_seq.sv
`default_nettype none
// ============================================================================
// Module   : llc_rst_flush_seq
// Brief    : Walks the LLC sets one at a time for reset (invalidate every
//            set) and flush (write back valid DATA ways, then invalidate
//            them). Owns the set counter and stall handling and returns a
//            single completion handshake to the LLC front end.
// Revision : 1.0 - initial release
// ============================================================================
module llc_rst_flush_seq
    import llc_rst_flush_seq_pkg::*;
#(
    parameter int SETS     = LLC_SETS,
    parameter int WAYS     = LLC_WAYS,
    parameter int SET_BITS = $clog2(SETS),
    parameter int WAY_BITS = idx_bits(WAYS)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                rst_req_valid,
    output logic                rst_req_ready,
    input  logic                flush_req_valid,
    output logic                flush_req_ready,

    input  logic                stall_i,

    output logic [SET_BITS-1:0] set_o,
    output logic                rd_en_o,
    input  logic [WAYS-1:0]     way_valid_i,
    input  logic [WAYS-1:0]     way_data_i,
    output logic                wr_rst_o,
    output logic [WAYS-1:0]     wr_flush_mask_o,

    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [WAY_BITS-1:0] wb_way_o,

    output logic                done_valid_o,
    input  logic                done_ready_i,
    output logic                done_is_flush_o
);

    localparam logic [SET_BITS-1:0] c_last_set = SET_BITS'(SETS - 1);

    llc_seq_state_t      r_state;
    logic [SET_BITS-1:0] r_cnt;
    logic [WAYS-1:0]     r_pend;
    logic [WAYS-1:0]     r_capt;
    logic                r_is_flush;

    logic                w_last_set;
    logic [WAYS-1:0]     w_chk_mask;
    logic [WAY_BITS-1:0] w_pick_idx;
    logic                w_pick_any;
    logic [WAYS-1:0]     w_pick_onehot;
    logic [WAYS-1:0]     w_pend_after;
    logic                w_idle;

    assign w_last_set    = (r_cnt == c_last_set);
    assign w_chk_mask    = way_valid_i & way_data_i;
    assign w_pick_onehot = WAYS'(1) << w_pick_idx;
    assign w_pend_after  = r_pend & ~w_pick_onehot;
    assign w_idle        = (r_state == ST_IDLE);

    // Next way to write back is the lowest pending bit.
    llc_way_pick #(
        .WAYS     (WAYS),
        .IDX_BITS (WAY_BITS)
    ) u_way_pick (
        .i_mask (r_pend),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    // Sequencer: request arbitration, set walk, writeback drain and completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pend     <= '0;
            r_capt     <= '0;
            r_is_flush <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    // Reset has priority when both requests arrive together.
                    if (rst_req_valid) begin
                        r_cnt   <= '0;
                        r_state <= ST_RST_WR;
                    end else if (flush_req_valid) begin
                        r_cnt   <= '0;
                        r_state <= ST_FL_RD;
                    end
                end
                ST_RST_WR: begin
                    if (!stall_i) begin
                        if (w_last_set) begin
                            r_is_flush <= 1'b0;
                            r_state    <= ST_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_FL_RD: begin
                    if (!stall_i) begin
                        r_state <= ST_FL_CHK;
                    end
                end
                ST_FL_CHK: begin
                    // Read data for the set arrives exactly one cycle after rd_en_o.
                    r_pend  <= w_chk_mask;
                    r_capt  <= w_chk_mask;
                    r_state <= (|w_chk_mask) ? ST_FL_WB : ST_FL_WR;
                end
                ST_FL_WB: begin
                    // The update pipeline stall does not apply to memory writebacks.
                    if (wb_ready_i) begin
                        r_pend <= w_pend_after;
                        if (w_pend_after == '0) begin
                            r_state <= ST_FL_WR;
                        end
                    end
                end
                ST_FL_WR: begin
                    if (w_last_set) begin
                        r_is_flush <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= ST_FL_RD;
                    end
                end
                ST_DONE: begin
                    if (done_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Readies and array commands are quiet while rst is high, so an aborted
    // walk never issues a write in the reset cycle itself.
    assign rst_req_ready   = !rst && w_idle;
    assign flush_req_ready = !rst && w_idle && !rst_req_valid;
    assign rd_en_o         = !rst && (r_state == ST_FL_RD)  && !stall_i;
    assign wr_rst_o        = !rst && (r_state == ST_RST_WR) && !stall_i;
    assign wr_flush_mask_o = (!rst && (r_state == ST_FL_WR)) ? r_capt : '0;

    // Valids are pure decodes of registered state, independent of the readies.
    assign set_o           = r_cnt;
    assign wb_valid_o      = (r_state == ST_FL_WB) && w_pick_any;
    assign wb_way_o        = (r_state == ST_FL_WB) ? w_pick_idx : '0;
    assign done_valid_o    = (r_state == ST_DONE);
    assign done_is_flush_o = (r_state == ST_DONE) && r_is_flush;

endmodule
`default_nettype wire

// File: tb/tb_llc_rst_flush_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_llc_rst_flush_seq
// Brief    : Self-checking bench for the LLC reset/flush set walker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_llc_rst_flush_seq;

    localparam int SETS     = 4;
    localparam int WAYS     = 16;
    localparam int SET_BITS = 2;
    localparam int WAY_BITS = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                rst_req_valid = 1'b0;
    logic                rst_req_ready;
    logic                flush_req_valid = 1'b0;
    logic                flush_req_ready;
    logic                stall_i = 1'b0;
    logic [SET_BITS-1:0] set_o;
    logic                rd_en_o;
    logic [WAYS-1:0]     way_valid_i;
    logic [WAYS-1:0]     way_data_i;
    logic                wr_rst_o;
    logic [WAYS-1:0]     wr_flush_mask_o;
    logic                wb_valid_o;
    logic                wb_ready_i = 1'b1;
    logic [WAY_BITS-1:0] wb_way_o;
    logic                done_valid_o;
    logic                done_ready_i = 1'b0;
    logic                done_is_flush_o;

    int total = 0;
    int bad   = 0;

    // Tag/state array contents per set, and a 1-cycle read model.
    logic [WAYS-1:0] tv [SETS];
    logic [WAYS-1:0] td [SETS];
    logic [WAYS-1:0] rv = '0;
    logic [WAYS-1:0] rdat = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en_o) begin
            rv   <= tv[set_o];
            rdat <= td[set_o];
        end
    end
    assign way_valid_i = rv;
    assign way_data_i  = rdat;

    llc_rst_flush_seq #(
        .SETS     (SETS),
        .WAYS     (WAYS),
        .SET_BITS (SET_BITS),
        .WAY_BITS (WAY_BITS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rst_req_valid   (rst_req_valid),
        .rst_req_ready   (rst_req_ready),
        .flush_req_valid (flush_req_valid),
        .flush_req_ready (flush_req_ready),
        .stall_i         (stall_i),
        .set_o           (set_o),
        .rd_en_o         (rd_en_o),
        .way_valid_i     (way_valid_i),
        .way_data_i      (way_data_i),
        .wr_rst_o        (wr_rst_o),
        .wr_flush_mask_o (wr_flush_mask_o),
        .wb_valid_o      (wb_valid_o),
        .wb_ready_i      (wb_ready_i),
        .wb_way_o        (wb_way_o),
        .done_valid_o    (done_valid_o),
        .done_ready_i    (done_ready_i),
        .done_is_flush_o (done_is_flush_o)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [28:0] outs;
        rst = 1'b1;
        cyc();
        cyc();
        #1;
        outs = {rst_req_ready, flush_req_ready, set_o, rd_en_o, wr_rst_o, wr_flush_mask_o,
                wb_valid_o, wb_way_o, done_valid_o, done_is_flush_o};
        total++;
        if (outs !== 29'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({rst_req_ready, flush_req_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_idle_ready: got %b want 11", {rst_req_ready, flush_req_ready});
        end
        cyc();
    endtask

    // mode 0: no stall, 1: stall on 2nd and 3rd cycles, 2: random stall
    task automatic test_reset_walk(input int mode);
        int wr_q[$];
        int n       = 0;
        int done_at = -1;
        int last_wr = -1;
        int stalls  = 0;
        int bad_wr  = 0;
        rst_req_valid = 1'b1;
        #1;
        total++;
        if (rst_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL walk_accept: got %b want 1", rst_req_ready);
        end
        cyc();
        rst_req_valid = 1'b0;
        while (done_at < 0 && n < 200) begin
            case (mode)
                1:       stall_i = (n == 1 || n == 2);
                2:       stall_i = ($urandom_range(0, 2) == 0);
                default: stall_i = 1'b0;
            endcase
            #1;
            if (done_valid_o) begin
                done_at = n;
            end else begin
                if (stall_i) stalls++;
                if (stall_i && wr_rst_o) bad_wr++;
                if (wr_rst_o) begin
                    wr_q.push_back(int'(set_o));
                    last_wr = n;
                end
                cyc();
                n++;
            end
        end
        stall_i = 1'b0;
        total++;
        if (done_at < 0) begin
            bad++;
            $display("FAIL walk_timeout: done_valid_o never rose (mode %0d)", mode);
        end
        total++;
        if (wr_q.size() != SETS) begin
            bad++;
            $display("FAIL walk_write_count: got %0d want %0d", wr_q.size(), SETS);
        end
        for (int i = 0; i < wr_q.size() && i < SETS; i++) begin
            total++;
            if (wr_q[i] != i) begin
                bad++;
                $display("FAIL walk_set_order[%0d]: got %0d want %0d", i, wr_q[i], i);
            end
        end
        total++;
        if (bad_wr != 0) begin
            bad++;
            $display("FAIL walk_write_in_stall: got %0d want 0", bad_wr);
        end
        total++;
        if (done_at != SETS + stalls || last_wr != done_at - 1) begin
            bad++;
            $display("FAIL walk_latency: done at %0d last write %0d want done %0d",
                     done_at, last_wr, SETS + stalls);
        end
        total++;
        if (done_is_flush_o !== 1'b0) begin
            bad++;
            $display("FAIL walk_done_kind: got %b want 0", done_is_flush_o);
        end
        // Completion must hold until accepted.
        cyc();
        #1;
        total++;
        if ({done_valid_o, done_is_flush_o} !== 2'b10) begin
            bad++;
            $display("FAIL walk_done_hold: got %b want 10", {done_valid_o, done_is_flush_o});
        end
        done_ready_i = 1'b1;
        cyc();
        done_ready_i = 1'b0;
        #1;
        total++;
        if ({done_valid_o, rst_req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL walk_done_release: got %b want 01", {done_valid_o, rst_req_ready});
        end
        cyc();
    endtask

    // mode 0: directed tables, no stall, ready high; 1: random everything;
    // 2: writeback ready held low for the first 3 offered cycles
    task automatic test_flush(input int mode);
        int exp_wb[$];
        int got_wb[$];
        int exp_ms[$];
        int got_ms[$];
        logic [WAYS-1:0] exp_mm[$];
        logic [WAYS-1:0] got_mm[$];
        logic [WAYS-1:0] m;
        logic [WAY_BITS-1:0] prev_way = '0;
        int  exp_cycles = 0;
        int  n          = 0;
        int  done_at    = -1;
        int  low_left   = 3;
        int  stab_err   = 0;
        int  stray      = 0;
        bit  wait_prev  = 1'b0;
        for (int s = 0; s < SETS; s++) begin
            tv[s] = 16'($urandom);
            td[s] = 16'($urandom);
            if ($urandom_range(0, 3) == 0) tv[s] = '0;
        end
        if (mode == 0) begin
            tv[0] = 16'h0005; td[0] = 16'h0007;
            tv[1] = 16'h0000; td[1] = 16'h0000;
        end else if (mode == 2) begin
            tv[0] = 16'h0012; td[0] = 16'hffff;
        end
        for (int s = 0; s < SETS; s++) begin
            m = tv[s] & td[s];
            exp_cycles += 3 + $countones(m);
            if (m != 0) begin
                exp_ms.push_back(s);
                exp_mm.push_back(m);
            end
            for (int w = 0; w < WAYS; w++) begin
                if (m[w]) exp_wb.push_back(s * WAYS + w);
            end
        end
        flush_req_valid = 1'b1;
        #1;
        total++;
        if (flush_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_accept: got %b want 1", flush_req_ready);
        end
        cyc();
        flush_req_valid = 1'b0;
        while (done_at < 0 && n < 3000) begin
            stall_i = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            case (mode)
                1:       wb_ready_i = ($urandom_range(0, 2) != 0);
                2:       wb_ready_i = (low_left == 0);
                default: wb_ready_i = 1'b1;
            endcase
            #1;
            if (done_valid_o) begin
                done_at = n;
            end else begin
                if (wait_prev && (!wb_valid_o || wb_way_o != prev_way)) stab_err++;
                wait_prev = wb_valid_o && !wb_ready_i;
                prev_way  = wb_way_o;
                if (wb_valid_o && !wb_ready_i && low_left > 0) low_left--;
                if (wb_valid_o && wb_ready_i) got_wb.push_back(int'(set_o) * WAYS + int'(wb_way_o));
                if (wr_flush_mask_o != '0) begin
                    got_ms.push_back(int'(set_o));
                    got_mm.push_back(wr_flush_mask_o);
                end
                if (wr_rst_o) stray++;
                cyc();
                n++;
            end
        end
        stall_i    = 1'b0;
        wb_ready_i = 1'b1;
        total++;
        if (done_at < 0) begin
            bad++;
            $display("FAIL flush_timeout: done_valid_o never rose (mode %0d)", mode);
        end
        total++;
        if (got_wb.size() != exp_wb.size()) begin
            bad++;
            $display("FAIL flush_wb_count: got %0d want %0d", got_wb.size(), exp_wb.size());
        end
        for (int i = 0; i < got_wb.size() && i < exp_wb.size(); i++) begin
            total++;
            if (got_wb[i] != exp_wb[i]) begin
                bad++;
                $display("FAIL flush_wb[%0d]: got set %0d way %0d want set %0d way %0d", i,
                         got_wb[i] / WAYS, got_wb[i] % WAYS, exp_wb[i] / WAYS, exp_wb[i] % WAYS);
            end
        end
        total++;
        if (got_ms.size() != exp_ms.size()) begin
            bad++;
            $display("FAIL flush_mask_count: got %0d want %0d", got_ms.size(), exp_ms.size());
        end
        for (int i = 0; i < got_ms.size() && i < exp_ms.size(); i++) begin
            total++;
            if (got_ms[i] != exp_ms[i] || got_mm[i] !== exp_mm[i]) begin
                bad++;
                $display("FAIL flush_mask[%0d]: got set %0d mask %h want set %0d mask %h", i,
                         got_ms[i], got_mm[i], exp_ms[i], exp_mm[i]);
            end
        end
        total++;
        if (stab_err != 0 || stray != 0) begin
            bad++;
            $display("FAIL flush_wb_stable: got %0d unstable %0d stray resets want 0 0", stab_err, stray);
        end
        total++;
        if (done_is_flush_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_done_kind: got %b want 1", done_is_flush_o);
        end
        if (mode == 0) begin
            total++;
            if (done_at != exp_cycles) begin
                bad++;
                $display("FAIL flush_latency: got %0d want %0d", done_at, exp_cycles);
            end
        end
        if (mode == 2) begin
            total++;
            if (low_left != 0) begin
                bad++;
                $display("FAIL flush_backpressure: got %0d stalled offers left want 0", low_left);
            end
        end
        done_ready_i = 1'b1;
        cyc();
        done_ready_i = 1'b0;
        #1;
        total++;
        if (done_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_done_release: got %b want 0", done_valid_o);
        end
        cyc();
    endtask

    task automatic test_both_requests();
        int n       = 0;
        int done_at = -1;
        int writes  = 0;
        int leak    = 0;
        for (int s = 0; s < SETS; s++) begin
            tv[s] = '0;
            td[s] = '0;
        end
        rst_req_valid   = 1'b1;
        flush_req_valid = 1'b1;
        #1;
        total++;
        if ({rst_req_ready, flush_req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL both_arbitration: got %b want 10", {rst_req_ready, flush_req_ready});
        end
        cyc();
        rst_req_valid = 1'b0;
        while (done_at < 0 && n < 100) begin
            #1;
            if (done_valid_o) begin
                done_at = n;
            end else begin
                if (wr_rst_o) writes++;
                if (flush_req_ready || rd_en_o) leak++;
                cyc();
                n++;
            end
        end
        total++;
        if (done_at != SETS || writes != SETS || leak != 0 || done_is_flush_o !== 1'b0) begin
            bad++;
            $display("FAIL both_reset_walk: got done %0d writes %0d leak %0d kind %b want %0d %0d 0 0",
                     done_at, writes, leak, done_is_flush_o, SETS, SETS);
        end
        done_ready_i = 1'b1;
        cyc();
        done_ready_i = 1'b0;
        #1;
        total++;
        if (flush_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL both_flush_ready: got %b want 1", flush_req_ready);
        end
        cyc();
        flush_req_valid = 1'b0;
        #1;
        total++;
        if (rd_en_o !== 1'b1 || set_o !== 2'd0) begin
            bad++;
            $display("FAIL both_flush_start: got rd %b set %0d want 1 0", rd_en_o, set_o);
        end
        n = 0;
        while (!done_valid_o && n < 100) begin
            cyc();
            #1;
            n++;
        end
        total++;
        if ({done_valid_o, done_is_flush_o} !== 2'b11) begin
            bad++;
            $display("FAIL both_flush_done: got %b want 11", {done_valid_o, done_is_flush_o});
        end
        done_ready_i = 1'b1;
        cyc();
        done_ready_i = 1'b0;
    endtask

    task automatic test_rst_abort();
        logic [28:0] outs;
        int  n     = 0;
        int  rises = 0;
        bit  found = 1'b0;
        tv[0] = '0;       td[0] = '0;
        tv[1] = 16'hffff; td[1] = 16'h00f0;
        tv[2] = 16'($urandom); td[2] = 16'($urandom);
        tv[3] = 16'($urandom); td[3] = 16'($urandom);
        wb_ready_i      = 1'b0;
        flush_req_valid = 1'b1;
        cyc();
        flush_req_valid = 1'b0;
        while (!found && n < 100) begin
            #1;
            if (wb_valid_o && set_o == 2'd1) begin
                found = 1'b1;
            end else begin
                cyc();
                n++;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL abort_reach_wb: never saw writeback on set 1");
        end
        rst = 1'b1;
        #1;
        total++;
        if ({wr_rst_o, rd_en_o, wr_flush_mask_o, rst_req_ready, flush_req_ready} !== 20'd0) begin
            bad++;
            $display("FAIL abort_reset_cycle: got %h want 0",
                     {wr_rst_o, rd_en_o, wr_flush_mask_o, rst_req_ready, flush_req_ready});
        end
        cyc();
        outs = {rst_req_ready, flush_req_ready, set_o, rd_en_o, wr_rst_o, wr_flush_mask_o,
                wb_valid_o, wb_way_o, done_valid_o, done_is_flush_o};
        total++;
        if (outs !== 29'd0) begin
            bad++;
            $display("FAIL abort_outputs: got %h want 0", outs);
        end
        rst = 1'b0;
        #1;
        total++;
        if (rst_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_idle: got %b want 1", rst_req_ready);
        end
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (done_valid_o || wb_valid_o) rises++;
        end
        total++;
        if (rises != 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d active cycles want 0", rises);
        end
        wb_ready_i = 1'b1;
    endtask

    initial begin
        for (int s = 0; s < SETS; s++) begin
            tv[s] = '0;
            td[s] = '0;
        end
        test_reset();
        test_reset_walk(0);
        test_reset_walk(1);
        test_reset_walk(2);
        test_flush(0);
        test_flush(2);
        for (int k = 0; k < 4; k++) test_flush(1);
        test_both_requests();
        test_rst_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
